bus_arbiter: RTL and testbench
==============================

# bus_arbiter

Round-robin arbiter and source sequencer for the shared 32-bit datapath bus. Up to NREQ requesters (control unit, I/O port, interrupt logic, debug) contend for bus ownership; the winner's source code is decoded into a registered one-hot drive-enable vector that feeds the bus multiplexer's per-source out selects (R0–R15, RA, PC, IR, HI, LO, MDR, MAR, Port, RZHI, RZLO, C). The arbiter guarantees that at most one source enable is high, inserts a dead cycle between owners, and can optionally force-release a stuck owner.

## Interface
- NREQ, 4, number of requesters (2–8)
- NSRC, 27, number of bus sources; src_en bit i drives source code i
- SRCW, 5, width of one source code, ceil(log2(NSRC))
- TIMEOUT, 16, maximum ownership in cycles (timeout build only, 2–255)

- clock  in  1  rising-edge clock
- clear  in  1  asynchronous, active-low reset
- req  in  NREQ  request/hold per requester; level, held for the whole ownership
- src_sel  in  NREQ*SRCW  source code per requester; requester k uses bits [k*SRCW +: SRCW]
- gnt  out  NREQ  registered one-hot grant; all zero when no owner
- src_en  out  NSRC  registered one-hot source drive enable; all zero when no owner or code invalid
- busy  out  1  high in GRANT and TURN
- bad_src  out  1  one-cycle pulse: owner presented code ≥ NSRC
- timeout_err  out  1  one-cycle pulse on forced release (timeout build only; tied 0 otherwise)

## Operation
- States: IDLE, GRANT, TURN. Reset → IDLE; gnt=0, src_en=0, busy=0, bad_src=0, timeout_err=0, rr pointer=0, mask=0, counter=0.
- IDLE: if any eligible req (req & ~mask) is high at an edge, grant the first eligible requester scanning from rr upward with wrap; → GRANT. Otherwise stay.
- Grant edge: gnt ← one-hot(winner); src_en ← decode(winner's src_sel); rr ← winner+1 mod NREQ.
- GRANT: each edge, if owner's req still high, src_en ← decode(owner's src_sel) (source change takes effect one cycle later); if owner's req low, gnt←0, src_en←0 → TURN.
- Invalid code (≥ NSRC): src_en←0 for that cycle, bad_src pulses high for one cycle; ownership unchanged.
- TURN: exactly one cycle with all outputs zero; → IDLE. Arbitration resumes on the edge leaving IDLE, so consecutive owners are separated by two cycles with gnt=0.
- Non-owner req changes in GRANT/TURN are ignored; requests are not latched — a req dropped before grant is lost.
- mask bit k set on forced release of k; cleared as soon as req[k] is sampled low.
- Simultaneous requests: rr order only; requester equal to rr has highest priority.
- clear asserted mid-ownership: all outputs zero immediately (asynchronous), state IDLE.

## Timing
- Request-to-grant latency: req high before edge N in IDLE → gnt and src_en valid after edge N (1 cycle).
- Release latency: req low before edge M in GRANT → gnt/src_en zero after edge M; new grant earliest after edge M+2.
- src_en and gnt change only on the same edges; never two bits high in either vector.
- busy is registered and equals (state != IDLE).

## Configuration
- BUS_ARB_TIMEOUT_EN defined: 8-bit counter clears at grant, increments each GRANT cycle; when it reaches TIMEOUT-1 with owner's req still high, next edge forces gnt=0, src_en=0, sets mask[owner], pulses timeout_err, → TURN.
- Undefined: no counter or mask logic; ownership lasts until req drops; timeout_err tied 0; mask stays 0.

## Test plan
- Reset: clear low with req=4'b1111 → all outputs 0; release clear, req[0] high, src_sel[0]=5'd17 (PC) → after 1 edge gnt=4'b0001, src_en bit 17 only.
- Round robin: req=4'b1111 held, each owner releases after 3 cycles → grant order 0,1,2,3,0 with two zero-gnt cycles between owners.
- Source change: owner switches src_sel 3→20 mid-ownership → src_en bit 3 for one more cycle then bit 20; never both.
- Invalid code: owner presents 5'd30 → src_en=0, bad_src one-cycle pulse, gnt unchanged.
- Timeout (BUS_ARB_TIMEOUT_EN, TIMEOUT=16): req[2] held 40 cycles, req[1] high → gnt[2] for 16 cycles, timeout_err pulse, TURN, gnt[1]; req[2] not regranted until dropped and reasserted.
- Async reset mid-GRANT: drop clear between edges → gnt/src_en 0 without a clock edge; after release, first grant follows rr=0.

Source files
------------

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with registered one-hot grant and source drive enables.
// Optional forced release of a stuck owner is built when BUS_ARB_TIMEOUT_EN is defined.
module bus_arbiter #(
    parameter int NREQ = 4,
    parameter int NSRC = 27,
    parameter int SRCW = 5
`ifdef BUS_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 16
`endif
) (
    input  logic                 clock,
    input  logic                 clear,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*SRCW-1:0] src_sel,
    output logic [NREQ-1:0]      gnt,
    output logic [NSRC-1:0]      src_en,
    output logic                 busy,
    output logic                 bad_src,
    output logic                 timeout_err,
    output logic [1:0]           fsm_state
);

    localparam int RRW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [SRCW:0] NSRC_LIM = (SRCW + 1)'(NSRC);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } state_t;

    state_t          state, state_next;
    logic [RRW-1:0]  rr_ptr, rr_next;
    logic [RRW-1:0]  owner, owner_next;
    logic [RRW-1:0]  win;
    logic            found;
    logic [NREQ-1:0] mask;
    logic [NREQ-1:0] eligible;
    logic [NREQ-1:0] gnt_next;
    logic [NSRC-1:0] src_en_next;
    logic            busy_next;
    logic            bad_next;
    logic [SRCW-1:0] codes [NREQ];
    logic [SRCW-1:0] code;
    logic            code_ok;
    logic [NSRC-1:0] code_dec;

`ifdef BUS_ARB_TIMEOUT_EN
    localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);
    logic [7:0]      count, count_next;
    logic [NREQ-1:0] mask_next;
    logic            te_next;
`else
    assign mask        = '0;
    assign timeout_err = 1'b0;
`endif

    assign fsm_state = state;
    assign eligible  = req & ~mask;

    always_comb begin
        for (int k = 0; k < NREQ; k++) begin
            codes[k] = src_sel[k*SRCW +: SRCW];
        end
    end

    // First eligible requester at or after rr_ptr, wrapping; all indices are
    // constants once the loops unroll.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int s = 0; s < NREQ; s++) begin
            if (rr_ptr == RRW'(s)) begin
                for (int i = 0; i < NREQ; i++) begin
                    if (!found && eligible[(s + i) % NREQ]) begin
                        found = 1'b1;
                        win   = RRW'((s + i) % NREQ);
                    end
                end
            end
        end
    end

    // In IDLE the winner's code is decoded for the grant edge; in GRANT the owner's.
    always_comb begin
        code     = codes[(state == IDLE) ? win : owner];
        code_ok  = ({1'b0, code} < NSRC_LIM);
        code_dec = '0;
        for (int i = 0; i < NSRC; i++) begin
            code_dec[i] = (code == SRCW'(i));
        end
    end

    always_comb begin
        state_next  = state;
        rr_next     = rr_ptr;
        owner_next  = owner;
        gnt_next    = '0;
        src_en_next = '0;
        bad_next    = 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
        count_next  = count;
        te_next     = 1'b0;
        mask_next   = mask & req;
`endif
        case (state)
            IDLE: begin
                if (found) begin
                    state_next    = GRANT;
                    owner_next    = win;
                    gnt_next[win] = 1'b1;
                    src_en_next   = code_dec;
                    bad_next      = !code_ok;
                    rr_next       = (win == RRW'(NREQ - 1)) ? '0 : win + RRW'(1);
`ifdef BUS_ARB_TIMEOUT_EN
                    count_next    = 8'd0;
`endif
                end
            end
            GRANT: begin
                if (!req[owner]) begin
                    state_next = TURN;
`ifdef BUS_ARB_TIMEOUT_EN
                end else if (count == LIMIT) begin
                    state_next       = TURN;
                    te_next          = 1'b1;
                    mask_next[owner] = 1'b1;
`endif
                end else begin
                    gnt_next    = gnt;
                    src_en_next = code_dec;
                    bad_next    = !code_ok;
`ifdef BUS_ARB_TIMEOUT_EN
                    count_next  = count + 8'd1;
`endif
                end
            end
            TURN:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state   <= IDLE;
            rr_ptr  <= '0;
            owner   <= '0;
            gnt     <= '0;
            src_en  <= '0;
            busy    <= 1'b0;
            bad_src <= 1'b0;
        end else begin
            state   <= state_next;
            rr_ptr  <= rr_next;
            owner   <= owner_next;
            gnt     <= gnt_next;
            src_en  <= src_en_next;
            busy    <= busy_next;
            bad_src <= bad_next;
        end
    end

`ifdef BUS_ARB_TIMEOUT_EN
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            count       <= 8'd0;
            mask        <= '0;
            timeout_err <= 1'b0;
        end else begin
            count       <= count_next;
            mask        <= mask_next;
            timeout_err <= te_next;
        end
    end
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: cycle table for arbitration/source decode, plus
// hand sequences for async reset and the long-ownership (timeout) case.
module tb_bus_arbiter;

    localparam int NREQ = 4;
    localparam int NSRC = 27;
    localparam int SRCW = 5;

    logic                 clock = 1'b0;
    logic                 clear;
    logic [NREQ-1:0]      req;
    logic [NREQ*SRCW-1:0] src_sel;
    logic [NREQ-1:0]      gnt;
    logic [NSRC-1:0]      src_en;
    logic                 busy;
    logic                 bad_src;
    logic                 timeout_err;
    logic [1:0]           fsm_state;

    int n_checks = 0;
    int n_fail   = 0;

    bus_arbiter #(.NREQ(NREQ), .NSRC(NSRC), .SRCW(SRCW)) dut (
        .clock       (clock),
        .clear       (clear),
        .req         (req),
        .src_sel     (src_sel),
        .gnt         (gnt),
        .src_en      (src_en),
        .busy        (busy),
        .bad_src     (bad_src),
        .timeout_err (timeout_err),
        .fsm_state   (fsm_state)
    );

    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [3:0] r;
        logic [4:0] c1;
        logic [3:0] g;
        int         e;
        logic       b;
        logic       bad;
    } vec_t;

    vec_t vecs[$];

    // Requesters 0, 2, 3 present fixed codes 17, 0, 26; requester 1's code varies.
    function automatic logic [19:0] pack_sel(input logic [4:0] c1);
        return {5'd26, 5'd0, c1, 5'd17};
    endfunction

    function automatic logic [NSRC-1:0] en_of(input int idx);
        logic [NSRC-1:0] one;
        one = 1;
        return (idx >= 0) ? (one << idx) : '0;
    endfunction

    function automatic vec_t mk(input logic [3:0] r, input logic [4:0] c1, input logic [3:0] g,
                                input int e, input logic b, input logic bad);
        vec_t v;
        v.r = r; v.c1 = c1; v.g = g; v.e = e; v.b = b; v.bad = bad;
        return v;
    endfunction

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [3:0] eg, input int ei,
                              input logic eb, input logic ebad, input logic ete);
        check_val({tag, " gnt"}, 32'(gnt), 32'(eg));
        check_val({tag, " src_en"}, 32'(src_en), 32'(en_of(ei)));
        check_val({tag, " busy"}, 32'(busy), 32'(eb));
        check_val({tag, " bad_src"}, 32'(bad_src), 32'(ebad));
        check_val({tag, " timeout_err"}, 32'(timeout_err), 32'(ete));
    endtask

    task automatic step(input logic [3:0] r, input logic [4:0] c1, input logic [3:0] eg,
                        input int ei, input logic eb, input logic ebad, input logic ete,
                        input string tag);
        @(negedge clock);
        req     = r;
        src_sel = pack_sel(c1);
        @(posedge clock);
        #1;
        check_outs(tag, eg, ei, eb, ebad, ete);
    endtask

    initial begin
        // round robin, each owner holds three cycles
        vecs.push_back(mk(4'b1111, 5'd5, 4'b0001, 17, 1'b1, 1'b0));
        vecs.push_back(mk(4'b1111, 5'd5, 4'b0001, 17, 1'b1, 1'b0));
        vecs.push_back(mk(4'b1111, 5'd5, 4'b0001, 17, 1'b1, 1'b0));
        vecs.push_back(mk(4'b1110, 5'd5, 4'b0000, -1, 1'b1, 1'b0));
        vecs.push_back(mk(4'b1111, 5'd5, 4'b0000, -1, 1'b0, 1'b0));
        vecs.push_back(mk(4'b1111, 5'd5, 4'b0010, 5, 1'b1, 1'b0));
        vecs.push_back(mk(4'b1111, 5'd5, 4'b0010, 5, 1'b1, 1'b0));
        vecs.push_back(mk(4'b1111, 5'd5, 4'b0010, 5, 1'b1, 1'b0));
        vecs.push_back(mk(4'b1101, 5'd5, 4'b0000, -1, 1'b1, 1'b0));
        vecs.push_back(mk(4'b1111, 5'd5, 4'b0000, -1, 1'b0, 1'b0));
        vecs.push_back(mk(4'b1111, 5'd5, 4'b0100, 0, 1'b1, 1'b0));
        vecs.push_back(mk(4'b1111, 5'd5, 4'b0100, 0, 1'b1, 1'b0));
        vecs.push_back(mk(4'b1111, 5'd5, 4'b0100, 0, 1'b1, 1'b0));
        vecs.push_back(mk(4'b1011, 5'd5, 4'b0000, -1, 1'b1, 1'b0));
        vecs.push_back(mk(4'b1111, 5'd5, 4'b0000, -1, 1'b0, 1'b0));
        vecs.push_back(mk(4'b1111, 5'd5, 4'b1000, 26, 1'b1, 1'b0));
        vecs.push_back(mk(4'b1111, 5'd5, 4'b1000, 26, 1'b1, 1'b0));
        vecs.push_back(mk(4'b1111, 5'd5, 4'b1000, 26, 1'b1, 1'b0));
        vecs.push_back(mk(4'b0111, 5'd5, 4'b0000, -1, 1'b1, 1'b0));
        vecs.push_back(mk(4'b1111, 5'd5, 4'b0000, -1, 1'b0, 1'b0));
        vecs.push_back(mk(4'b1111, 5'd5, 4'b0001, 17, 1'b1, 1'b0));
        vecs.push_back(mk(4'b0000, 5'd5, 4'b0000, -1, 1'b1, 1'b0));
        vecs.push_back(mk(4'b0000, 5'd5, 4'b0000, -1, 1'b0, 1'b0));
        vecs.push_back(mk(4'b0000, 5'd5, 4'b0000, -1, 1'b0, 1'b0));
        // source change 3 -> 20, invalid codes 30 and 27, top valid code 26
        vecs.push_back(mk(4'b0010, 5'd3, 4'b0010, 3, 1'b1, 1'b0));
        vecs.push_back(mk(4'b0010, 5'd20, 4'b0010, 20, 1'b1, 1'b0));
        vecs.push_back(mk(4'b0010, 5'd20, 4'b0010, 20, 1'b1, 1'b0));
        vecs.push_back(mk(4'b0010, 5'd30, 4'b0010, -1, 1'b1, 1'b1));
        vecs.push_back(mk(4'b0010, 5'd20, 4'b0010, 20, 1'b1, 1'b0));
        vecs.push_back(mk(4'b0010, 5'd27, 4'b0010, -1, 1'b1, 1'b1));
        vecs.push_back(mk(4'b0010, 5'd26, 4'b0010, 26, 1'b1, 1'b0));
        vecs.push_back(mk(4'b0000, 5'd26, 4'b0000, -1, 1'b1, 1'b0));
        vecs.push_back(mk(4'b0000, 5'd26, 4'b0000, -1, 1'b0, 1'b0));
        // simultaneous requests with rr=2, then requests held through TURN
        vecs.push_back(mk(4'b1001, 5'd26, 4'b1000, 26, 1'b1, 1'b0));
        vecs.push_back(mk(4'b0000, 5'd26, 4'b0000, -1, 1'b1, 1'b0));
        vecs.push_back(mk(4'b1001, 5'd26, 4'b0000, -1, 1'b0, 1'b0));
        vecs.push_back(mk(4'b1001, 5'd26, 4'b0001, 17, 1'b1, 1'b0));
        vecs.push_back(mk(4'b0000, 5'd26, 4'b0000, -1, 1'b1, 1'b0));
        vecs.push_back(mk(4'b0000, 5'd26, 4'b0000, -1, 1'b0, 1'b0));

        // reset with all requests high
        clear   = 1'b0;
        req     = 4'b1111;
        src_sel = pack_sel(5'd5);
        repeat (3) @(negedge clock);
        check_outs("reset", 4'b0000, -1, 1'b0, 1'b0, 1'b0);
        check_val("reset fsm_state", 32'(fsm_state), 32'd0);
        clear = 1'b1;
        req   = 4'b0000;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].r, vecs[i].c1, vecs[i].g, vecs[i].e, vecs[i].b, vecs[i].bad,
                 1'b0, $sformatf("vec%0d", i));
        end

        // asynchronous reset while requester 2 owns the bus
        step(4'b0100, 5'd26, 4'b0100, 0, 1'b1, 1'b0, 1'b0, "async_grant");
        #2;
        clear = 1'b0;
        #1;
        check_outs("async_clear", 4'b0000, -1, 1'b0, 1'b0, 1'b0);
        check_val("async_clear fsm_state", 32'(fsm_state), 32'd0);
        @(negedge clock);
        clear = 1'b1;
        req   = 4'b0000;
        step(4'b1111, 5'd26, 4'b0001, 17, 1'b1, 1'b0, 1'b0, "async_rr0");
        step(4'b0000, 5'd26, 4'b0000, -1, 1'b1, 1'b0, 1'b0, "async_turn");
        step(4'b0000, 5'd26, 4'b0000, -1, 1'b0, 1'b0, 1'b0, "async_idle");

        // requester 2 holds its request for a long time while requester 1 waits
        step(4'b0100, 5'd26, 4'b0100, 0, 1'b1, 1'b0, 1'b0, "long_grant");
`ifdef BUS_ARB_TIMEOUT_EN
        for (int k = 2; k <= 16; k++) begin
            step(4'b0110, 5'd26, 4'b0100, 0, 1'b1, 1'b0, 1'b0, $sformatf("to_hold%0d", k));
        end
        step(4'b0110, 5'd26, 4'b0000, -1, 1'b1, 1'b0, 1'b1, "to_release");
        step(4'b0110, 5'd26, 4'b0000, -1, 1'b0, 1'b0, 1'b0, "to_idle");
        step(4'b0110, 5'd26, 4'b0010, 26, 1'b1, 1'b0, 1'b0, "to_next_owner");
        step(4'b0100, 5'd26, 4'b0000, -1, 1'b1, 1'b0, 1'b0, "to_turn2");
        step(4'b0100, 5'd26, 4'b0000, -1, 1'b0, 1'b0, 1'b0, "to_idle2");
        step(4'b0100, 5'd26, 4'b0000, -1, 1'b0, 1'b0, 1'b0, "to_masked");
        step(4'b0000, 5'd26, 4'b0000, -1, 1'b0, 1'b0, 1'b0, "to_unmask");
        step(4'b0100, 5'd26, 4'b0100, 0, 1'b1, 1'b0, 1'b0, "to_regrant");
`else
        for (int k = 2; k <= 40; k++) begin
            step(4'b0110, 5'd26, 4'b0100, 0, 1'b1, 1'b0, 1'b0, $sformatf("hold%0d", k));
        end
        step(4'b0010, 5'd26, 4'b0000, -1, 1'b1, 1'b0, 1'b0, "hold_release");
        step(4'b0010, 5'd26, 4'b0000, -1, 1'b0, 1'b0, 1'b0, "hold_idle");
        step(4'b0010, 5'd26, 4'b0010, 26, 1'b1, 1'b0, 1'b0, "hold_next_owner");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
